// File: rtl/sisc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_ctrl_fsm_if
//  Purpose  : Bundle of signals between the SISC control FSM and the
//             datapath. The datapath (IR, status register, data memory)
//             supplies the instruction fields, flags and memory-ready. The
//             controller returns every write/select strobe, the halted flag
//             and the retired-instruction count.
//  Modports : master - control FSM side (consumes IR/status, drives strobes)
//             slave  - datapath side (drives IR/status, consumes strobes)
//  Signals  : opcode    IR opcode field
//             mm        IR mm field (ALU immediate select / branch mask)
//             stat      ALU status flags
//             mem_rdy   data memory transfer complete
//             pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel,
//             alu_op[1:0], wb_sel, rf_we, dm_we   datapath strobes
//             halted    controller parked in HALT
//             instr_cnt retired-instruction count
//  Revision : 1.0  initial release
// ============================================================================
interface sisc_ctrl_fsm_if #(
    parameter int OP_W   = 4,
    parameter int MM_W   = 4,
    parameter int STAT_W = 4,
    parameter int CNT_W  = 16
);
    // Instruction fields and datapath status
    logic [OP_W-1:0]   opcode;
    logic [MM_W-1:0]   mm;
    logic [STAT_W-1:0] stat;
    logic              mem_rdy;

    // Datapath strobes and selects
    logic              pc_rst;
    logic              pc_write;
    logic              pc_sel;
    logic              br_sel;
    logic              ir_load;
    logic              rb_sel;
    logic [1:0]        alu_op;
    logic              wb_sel;
    logic              rf_we;
    logic              dm_we;

    // Status back to the system
    logic              halted;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        input  opcode, mm, stat, mem_rdy,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel,
               alu_op, wb_sel, rf_we, dm_we, halted, instr_cnt
    );

    modport slave (
        output opcode, mm, stat, mem_rdy,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel,
               alu_op, wb_sel, rf_we, dm_we, halted, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sisc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_ctrl_fsm
//  Purpose  : Multi-cycle control unit for the SISC datapath. Sequences each
//             instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK,
//             decodes LOD/STR/branch/ALU opcodes into datapath strobes,
//             optionally stretches MEM until the data memory is ready, parks
//             in a terminal HALT state on HLT, and counts retired
//             instructions.
//  Ports    : clk       clock, rising edge
//             rst_f     asynchronous active-low reset
//             bus       sisc_ctrl_fsm_if.master
//                         in : opcode, mm, stat, mem_rdy
//                         out: pc_rst, pc_write, pc_sel, br_sel, ir_load,
//                              rb_sel, alu_op, wb_sel, rf_we, dm_we,
//                              halted, instr_cnt
//  Params   : OP_W      opcode width
//             MM_W      mm field / branch mask width
//             STAT_W    status flag width (normally equal to MM_W)
//             MEM_WAIT  1: LOD/STR hold in MEM until mem_rdy, 0: single MEM
//             CNT_W     retired-instruction counter width
//  Revision : 1.0  initial release
// ============================================================================
module sisc_ctrl_fsm #(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int STAT_W   = 4,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst_f,
    sisc_ctrl_fsm_if.master bus
);

    // ------------------------------------------------------------------
    // Opcode encodings and field constants
    // ------------------------------------------------------------------
    localparam logic [OP_W-1:0] c_OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_BNR = OP_W'(7);
    localparam logic [OP_W-1:0] c_OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] c_OP_HLT = OP_W'(15);

    // mm value that selects the ALU immediate operand
    localparam logic [MM_W-1:0] c_MM_IMM = MM_W'(8);

    // Only the overlapping bits of mask and flags take part in branch tests
    localparam int c_FLAG_W = (MM_W < STAT_W) ? MM_W : STAT_W;

    // ALU function codes
    localparam logic [1:0] c_ALU_ADD  = 2'b01;   // address: base + offset
    localparam logic [1:0] c_ALU_IDLE = 2'b10;   // idle / pass-through

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instr_cnt;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic w_is_lod;
    logic w_is_str;
    logic w_is_bra;
    logic w_is_brr;
    logic w_is_bne;
    logic w_is_bnr;
    logic w_is_alu;
    logic w_is_hlt;
    logic w_imm_mode;
    logic w_flag_hit;
    logic w_br_taken;
    logic w_br_abs;
    logic w_mem_op;
    logic w_mem_stall;

    assign w_is_lod   = (bus.opcode == c_OP_LOD);
    assign w_is_str   = (bus.opcode == c_OP_STR);
    assign w_is_bra   = (bus.opcode == c_OP_BRA);
    assign w_is_brr   = (bus.opcode == c_OP_BRR);
    assign w_is_bne   = (bus.opcode == c_OP_BNE);
    assign w_is_bnr   = (bus.opcode == c_OP_BNR);
    assign w_is_alu   = (bus.opcode == c_OP_ALU);
    assign w_is_hlt   = (bus.opcode == c_OP_HLT);
    assign w_imm_mode = (bus.mm == c_MM_IMM);
    assign w_mem_op   = w_is_lod | w_is_str;

    // Any masked flag set: BRA/BRR branch on it, BNE/BNR on its absence.
    assign w_flag_hit = |(bus.stat[c_FLAG_W-1:0] & bus.mm[c_FLAG_W-1:0]);
    assign w_br_taken = ((w_is_bra | w_is_brr) &  w_flag_hit) |
                        ((w_is_bne | w_is_bnr) & ~w_flag_hit);
    // BRA/BNE use the absolute target, BRR/BNR the PC-relative one.
    assign w_br_abs   = w_is_bra | w_is_bne;

    // Memory-ready handshake only exists in the waiting build; otherwise
    // MEM is a fixed single cycle and mem_rdy is never looked at.
    generate
        if (MEM_WAIT != 0) begin : g_mem_wait
            assign w_mem_stall = w_mem_op & ~bus.mem_rdy;
        end else begin : g_no_mem_wait
            logic w_unused_rdy;
            assign w_unused_rdy = bus.mem_rdy;
            assign w_mem_stall  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register and retired-instruction counter
    // ------------------------------------------------------------------
    // Reset lands in START1 (not START0) so the PC clear strobe is active
    // for as long as rst_f is held and for the cycle after its release.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_START1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every WRITEBACK is followed by FETCH, so a WRITEBACK cycle is exactly
    // one retirement. The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_instr_cnt <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_START0:    w_next_state = S_START1;
            S_START1:    w_next_state = S_FETCH;
            S_FETCH:     w_next_state = S_DECODE;
            S_DECODE:    w_next_state = w_is_hlt ? S_HALT : S_EXECUTE;
            S_EXECUTE:   w_next_state = S_MEM;
            S_MEM:       w_next_state = w_mem_stall ? S_MEM : S_WRITEBACK;
            S_WRITEBACK: w_next_state = S_FETCH;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_START1;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore on state, Mealy on IR fields / flags)
    // ------------------------------------------------------------------
    logic       w_pc_rst;
    logic       w_pc_write;
    logic       w_pc_sel;
    logic       w_br_sel;
    logic       w_ir_load;
    logic       w_rb_sel;
    logic [1:0] w_alu_op;
    logic       w_wb_sel;
    logic       w_rf_we;
    logic       w_dm_we;
    logic       w_halted;

    always_comb begin
        w_pc_rst   = 1'b0;
        w_pc_write = 1'b0;
        w_pc_sel   = 1'b0;
        w_br_sel   = 1'b0;
        w_ir_load  = 1'b0;
        w_rb_sel   = 1'b0;
        w_alu_op   = c_ALU_IDLE;
        w_wb_sel   = 1'b0;
        w_rf_we    = 1'b0;
        w_dm_we    = 1'b0;
        w_halted   = 1'b0;

        case (r_state)
            S_START1: begin
                w_pc_rst = 1'b1;
            end

            S_FETCH: begin
                // Latch the instruction and step the PC to PC+1.
                w_ir_load  = 1'b1;
                w_pc_write = 1'b1;
                w_pc_sel   = 1'b0;
            end

            S_EXECUTE: begin
                if (w_is_alu) begin
                    w_alu_op = {1'b0, w_imm_mode};
                end else if (w_mem_op) begin
                    w_alu_op = c_ALU_ADD;
                    w_rb_sel = w_is_str;
                end else if (w_br_taken) begin
                    // Not-taken branches fall through on the PC+1 already
                    // written in FETCH, so no PC strobe is needed.
                    w_pc_write = 1'b1;
                    w_pc_sel   = 1'b1;
                    w_br_sel   = w_br_abs;
                end
            end

            S_MEM: begin
                if (w_is_alu) begin
                    w_alu_op = {1'b1, w_imm_mode};
                end else if (w_mem_op) begin
                    // Address and store data are held steady for the whole
                    // wait so the memory sees a stable request.
                    w_alu_op = c_ALU_ADD;
                    w_rb_sel = w_is_str;
                    w_dm_we  = w_is_str;
                end
            end

            S_WRITEBACK: begin
                if (w_is_alu) begin
                    w_rf_we  = 1'b1;
                    w_wb_sel = 1'b0;
                end else if (w_is_lod) begin
                    w_rf_we  = 1'b1;
                    w_wb_sel = 1'b1;
                end
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign bus.pc_rst    = w_pc_rst;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.br_sel    = w_br_sel;
    assign bus.ir_load   = w_ir_load;
    assign bus.rb_sel    = w_rb_sel;
    assign bus.alu_op    = w_alu_op;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.rf_we     = w_rf_we;
    assign bus.dm_we     = w_dm_we;
    assign bus.halted    = w_halted;
    assign bus.instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sisc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sisc_ctrl_fsm
//  Purpose  : Self-checking bench for sisc_ctrl_fsm. Directed instructions
//             are driven cycle by cycle; for each cycle the bench derives the
//             expected strobe vector from the instruction semantics and
//             queues it, and a negedge compare process checks the DUT
//             against that queue. A few literal checks pin counter and
//             reset/halt behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sisc_ctrl_fsm;

    localparam int c_CNT_W    = 4;   // small so the wrap is reachable
    localparam int c_MEM_WAIT = 1;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       ir_load;
        logic       rb_sel;
        logic [1:0] alu_op;
        logic       wb_sel;
        logic       rf_we;
        logic       dm_we;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t              o;
        logic [c_CNT_W-1:0] cnt;
        string              name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_f;

    sisc_ctrl_fsm_if #(.OP_W(4), .MM_W(4), .STAT_W(4), .CNT_W(c_CNT_W)) bus ();

    sisc_ctrl_fsm #(
        .OP_W(4), .MM_W(4), .STAT_W(4), .MEM_WAIT(c_MEM_WAIT), .CNT_W(c_CNT_W)
    ) dut (
        .clk  (clk),
        .rst_f(rst_f),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    outs_t w_act;
    assign w_act = {bus.pc_rst, bus.pc_write, bus.pc_sel, bus.br_sel, bus.ir_load,
                    bus.rb_sel, bus.alu_op, bus.wb_sel, bus.rf_we, bus.dm_we, bus.halted};

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_cnt = 0;

    // ---------------- reference model: per-phase expected outputs ----------
    function automatic outs_t idle();
        outs_t o = '0;
        o.alu_op = 2'b10;
        return o;
    endfunction

    function automatic outs_t start1_outs();
        outs_t o = idle();
        o.pc_rst = 1'b1;
        return o;
    endfunction

    function automatic outs_t fetch_outs();
        outs_t o = idle();
        o.ir_load  = 1'b1;
        o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic outs_t halt_outs();
        outs_t o = idle();
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic outs_t exec_outs(input int op, input int mmv, input int st);
        outs_t o   = idle();
        bit    hit = ((st & mmv) != 0);
        case (op)
            8: o.alu_op = {1'b0, (mmv == 8)};
            1: o.alu_op = 2'b01;
            2: begin o.alu_op = 2'b01; o.rb_sel = 1'b1; end
            4, 5, 6, 7: begin
                if ((op < 6) ? hit : !hit) begin
                    o.pc_write = 1'b1;
                    o.pc_sel   = 1'b1;
                    o.br_sel   = (op == 4 || op == 6);
                end
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t mem_outs(input int op, input int mmv);
        outs_t o = idle();
        case (op)
            8: o.alu_op = {1'b1, (mmv == 8)};
            1: o.alu_op = 2'b01;
            2: begin o.alu_op = 2'b01; o.rb_sel = 1'b1; o.dm_we = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t wb_outs(input int op);
        outs_t o = idle();
        if (op == 8) o.rf_we = 1'b1;
        if (op == 1) begin o.rf_we = 1'b1; o.wb_sel = 1'b1; end
        return o;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (w_act !== e.o || bus.instr_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                         e.name, w_act, bus.instr_cnt, e.o, e.cnt);
            end
        end
    end

    task automatic chk_lit(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input outs_t o, input string name);
        exp_t e;
        e.o    = o;
        e.cnt  = c_CNT_W'(model_cnt);
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Drop rst_f between edges; the effect must be visible before any clock.
    task automatic reset_now(input string why);
        rst_f = 1'b0;
        #1;
        model_cnt = 0;
        chk_lit({why, " cnt async clear"}, int'(bus.instr_cnt), 0);
        chk_lit({why, " pc_rst async"}, int'(bus.pc_rst), 1);
        cyc(start1_outs(), {why, " START1 held"});
        rst_f = 1'b1;
        cyc(start1_outs(), {why, " START1 release"});
    endtask

    // One instruction from FETCH to the next FETCH. nwait = cycles mem_rdy
    // stays low in MEM; abort_at >= 0 drops reset in that MEM cycle.
    task automatic run_instr(input int op, input int mmv, input int st,
                             input int nwait, input int abort_at);
        string tag;
        int    waits;
        bit    mem_op;
        tag    = $sformatf("op%0d mm%0h st%0h", op, mmv, st);
        mem_op = (op == 1 || op == 2);
        bus.opcode  = 4'(op);
        bus.mm      = 4'(mmv);
        bus.stat    = 4'(st);
        bus.mem_rdy = 1'b0;
        cyc(fetch_outs(), {tag, " FETCH"});
        cyc(idle(), {tag, " DECODE"});
        if (op == 15) begin
            for (int i = 0; i < 4; i++) begin
                bus.mem_rdy = i[0];
                cyc(halt_outs(), {tag, " HALT"});
            end
            return;
        end
        bus.mem_rdy = 1'b1;   // must be ignored outside MEM
        cyc(exec_outs(op, mmv, st), {tag, " EXECUTE"});
        waits = (c_MEM_WAIT != 0 && mem_op) ? nwait : 0;
        for (int i = 0; i <= waits; i++) begin
            bus.mem_rdy = mem_op ? (i == waits) : 1'b0;
            if (i == abort_at) begin
                reset_now({tag, " abort"});
                return;
            end
            cyc(mem_outs(op, mmv), {tag, " MEM"});
        end
        bus.mem_rdy = 1'b0;
        cyc(wb_outs(op), {tag, " WB"});
        model_cnt = (model_cnt + 1) % (1 << c_CNT_W);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_f       = 1'b0;
        bus.opcode  = '0;
        bus.mm      = '0;
        bus.stat    = '0;
        bus.mem_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_lit("reset cnt", int'(bus.instr_cnt), 0);
        chk_lit("reset pc_rst", int'(bus.pc_rst), 1);
        cyc(start1_outs(), "START1 in reset");
        rst_f = 1'b1;
        cyc(start1_outs(), "START1 release");

        run_instr(8, 8, 0, 0, -1);               // ALU immediate
        chk_lit("cnt after first ALU", int'(bus.instr_cnt), 1);
        run_instr(8, 3, 0, 0, -1);               // ALU register mode
        run_instr(4, 4'b0010, 4'b0010, 0, -1);   // BRA taken
        run_instr(4, 4'b0010, 4'b0000, 0, -1);   // BRA not taken
        run_instr(7, 4'b0001, 4'b0000, 0, -1);   // BNR taken, relative
        run_instr(6, 4'b0001, 4'b0001, 0, -1);   // BNE not taken
        run_instr(5, 4'b1100, 4'b0100, 0, -1);   // BRR taken, relative
        run_instr(6, 4'b0011, 4'b0000, 0, -1);   // BNE taken, absolute
        run_instr(2, 0, 0, 3, -1);               // STR, 4 MEM cycles
        run_instr(1, 5, 0, 2, -1);               // LOD, 3 MEM cycles
        run_instr(1, 0, 0, 0, -1);               // LOD, ready at once
        run_instr(0, 0, 0, 0, -1);               // NOOP
        run_instr(3, 0, 0, 0, -1);               // SWP
        chk_lit("cnt after 13", int'(bus.instr_cnt), 13);
        for (int k = 0; k < 2; k++) run_instr(0, 0, 0, 0, -1);
        chk_lit("cnt at max", int'(bus.instr_cnt), 15);
        run_instr(0, 0, 0, 0, -1);
        chk_lit("cnt wrap", int'(bus.instr_cnt), 0);

        run_instr(8, 8, 0, 0, -1);
        run_instr(8, 1, 0, 0, -1);
        chk_lit("cnt before abort", int'(bus.instr_cnt), 2);
        run_instr(2, 0, 0, 5, 2);                // reset mid MEM wait

        run_instr(8, 8, 0, 0, -1);
        run_instr(15, 0, 0, 0, -1);              // HLT
        chk_lit("halted", int'(bus.halted), 1);
        chk_lit("cnt frozen in HALT", int'(bus.instr_cnt), 1);
        reset_now("halt recover");
        chk_lit("halted cleared", int'(bus.halted), 0);
        run_instr(8, 8, 0, 0, -1);
        chk_lit("cnt after recover", int'(bus.instr_cnt), 1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
